// File: rtl/pipe_msg_pkg.sv
// Package: pipe_msg_pkg
// Purpose : Shared widths, beat-count helper, message struct and serializer
//           state type for the pipe message stages (M2P, P2M, serializer).
// Contents: DATA_W/HDR_W/PAYLOAD_W/MSG_W constants, nbeats_of() helper,
//           NBEATS/IDX_W derived constants, pipe_msg_t, ser_state_e.
package pipe_msg_pkg;

  localparam int DATA_W    = 32;
  localparam int HDR_W     = 16;
  localparam int PAYLOAD_W = 128;
  localparam int MSG_W     = HDR_W + PAYLOAD_W;

  // One header beat plus one beat per payload word.
  function automatic int nbeats_of(input int data_w, input int payload_w);
    return 1 + payload_w / data_w;
  endfunction

  localparam int NBEATS = nbeats_of(DATA_W, PAYLOAD_W);
  localparam int IDX_W  = $clog2(NBEATS);

  // Packed so that hdr lands in the top HDR_W bits of the MSG_W vector.
  typedef struct packed {
    logic [HDR_W-1:0]     hdr;
    logic [PAYLOAD_W-1:0] payload;
  } pipe_msg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } ser_state_e;

endpackage

// File: rtl/pipe_msg_serializer_if.sv
// Interface: pipe_msg_serializer_if
// Purpose  : Bundles the message-enqueue side and the beat side of the
//            serializer.
// Signals  : enq_ena/enq_v/enq_rdy - message offer, data, acceptance
//            beat_ena/beat_v/beat_last/beat_rdy - beat transfer handshake
//            msg_count - messages fully sent (8-bit, wraps)
// Modports : master (producer/consumer environment), slave (serializer)
interface pipe_msg_serializer_if;
  import pipe_msg_pkg::*;

  logic              enq_ena;
  pipe_msg_t         enq_v;
  logic              enq_rdy;
  logic              beat_ena;
  logic [DATA_W-1:0] beat_v;
  logic              beat_last;
  logic              beat_rdy;
  logic [7:0]        msg_count;

  modport master (
    output enq_ena, enq_v, beat_rdy,
    input  enq_rdy, beat_ena, beat_v, beat_last, msg_count
  );

  modport slave (
    input  enq_ena, enq_v, beat_rdy,
    output enq_rdy, beat_ena, beat_v, beat_last, msg_count
  );

endinterface

// File: rtl/pipe_msg_hold.sv
// Module : pipe_msg_hold
// Purpose: One-entry message register with a valid flag. Used as the
//          serializer's working register and, optionally, as its skid entry.
// Ports  : clk, rst (sync, active-high)
//          load  - capture din and set valid (wins over clear)
//          clear - drop valid
//          din/dout - message in/out, valid - entry occupied
module pipe_msg_hold
  import pipe_msg_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      clear,
  input  pipe_msg_t din,
  output pipe_msg_t dout,
  output logic      valid
);

  // Load has priority so a retiring entry can be refilled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_msg_serializer.sv
// Module : pipe_msg_serializer
// Purpose: Splits 144-bit pipe messages {hdr, payload} into 32-bit beats:
//          a length-tagged header beat {hdr, zeros, NBEATS} followed by the
//          payload words, most significant word first.
// Ports  : clk  - rising-edge clock
//          rst  - synchronous reset, active-high
//          bus  - pipe_msg_serializer_if.slave (enq handshake, beat
//                 handshake, msg_count)
// Config : define PIPE_MSG_SERIALIZER_SKID_EN to add a one-entry skid
//          register so back-to-back messages stream with no idle cycle.
module pipe_msg_serializer
  import pipe_msg_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  pipe_msg_serializer_if.slave bus
);

  ser_state_e           state;
  logic [IDX_W-1:0]     beat_idx;
  logic [7:0]           msg_count;
  pipe_msg_t            work_msg;
  pipe_msg_t            work_din;
  logic                 work_valid;
  logic                 work_load;
  logic                 live;
  logic                 xfer;
  logic                 last_xfer;
  logic                 accept;
  logic [DATA_W-1:0]    beat_data;
  logic [PAYLOAD_W-1:0] payload_shift;

  // Everything is forced quiet while reset is held, so a message cut off
  // by reset never leaks a beat.
  assign live      = !rst && work_valid && (state != IDLE);
  assign xfer      = live && bus.beat_rdy;
  assign last_xfer = xfer && (state == BODY) && (beat_idx == IDX_W'(NBEATS - 1));
  assign accept    = bus.enq_ena && bus.enq_rdy;

`ifdef PIPE_MSG_SERIALIZER_SKID_EN
  pipe_msg_t skid_msg;
  logic      skid_valid;
  logic      skid_load;
  logic      skid_clear;

  // A message arriving mid-drain is parked; on the last beat the parked
  // message (or one arriving on that very cycle) becomes the working one.
  assign bus.enq_rdy = !rst && !skid_valid;
  assign skid_load   = accept && (state != IDLE) && !last_xfer;
  assign skid_clear  = last_xfer && skid_valid;
  assign work_load   = (accept && ((state == IDLE) || last_xfer)) || skid_clear;
  assign work_din    = skid_valid ? skid_msg : bus.enq_v;

  pipe_msg_hold u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (bus.enq_v),
    .dout  (skid_msg),
    .valid (skid_valid)
  );
`else
  assign bus.enq_rdy = !rst && (state == IDLE);
  assign work_load   = accept;
  assign work_din    = bus.enq_v;
`endif

  pipe_msg_hold u_work (
    .clk   (clk),
    .rst   (rst),
    .load  (work_load),
    .clear (last_xfer),
    .din   (work_din),
    .dout  (work_msg),
    .valid (work_valid)
  );

  // Sequencing: a capture restarts at the header beat; each transfer
  // advances one beat; the last body beat retires the message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_idx  <= '0;
      msg_count <= '0;
    end else begin
      if (work_load) begin
        state    <= HDR;
        beat_idx <= '0;
      end else if (xfer) begin
        if (state == HDR) begin
          state    <= BODY;
          beat_idx <= IDX_W'(1);
        end else if (last_xfer) begin
          state    <= IDLE;
          beat_idx <= '0;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end
      if (last_xfer) begin
        msg_count <= msg_count + 8'd1;
      end
    end
  end

  // Beat data comes straight from registered state, so it stays stable
  // across stall cycles. Body beat k takes payload word k-1 from the top.
  always_comb begin
    beat_data     = '0;
    payload_shift = '0;
    if (live) begin
      if (state == HDR) begin
        beat_data = {work_msg.hdr, {(DATA_W - HDR_W - 8){1'b0}}, 8'(NBEATS)};
      end else begin
        payload_shift = work_msg.payload << (DATA_W * (int'(beat_idx) - 1));
        beat_data     = payload_shift[PAYLOAD_W-1 -: DATA_W];
      end
    end
  end

  assign bus.beat_ena  = xfer;
  assign bus.beat_v    = beat_data;
  assign bus.beat_last = live && (state == BODY) && (beat_idx == IDX_W'(NBEATS - 1));
  assign bus.msg_count = msg_count;

endmodule
